adc_y_emu: RTL

ADC_Y_EMU -- requirements
Module: adc_y_emu

---
 rtl/adc_y_emu_pkg.sv | 20 ++
 rtl/adc_y_emu_sync_fifo.sv | 57 +++++
 rtl/adc_y_emu.sv | 91 +++++++++
 3 files changed

// File: rtl/adc_y_emu_pkg.sv
// Shared types for the ADC emulator: how each output update slot is sourced.
package adc_y_emu_pkg;

  typedef enum logic [1:0] {
    SRC_HOLD,
    SRC_RAMP,
    SRC_FIFO,
    SRC_UNDER
  } upd_src_e;

  // Buffer emptiness is the registered state, so a push landing on the
  // update edge is only seen in the next period.
  function automatic upd_src_e pick_src(logic upd, logic pat, logic empty);
    if (!upd)  return SRC_HOLD;
    if (pat)   return SRC_RAMP;
    if (empty) return SRC_UNDER;
    return SRC_FIFO;
  endfunction

endpackage

// File: rtl/adc_y_emu_sync_fifo.sv
// Single-clock sample buffer with registered occupancy; full blocks pushes.
module sync_fifo #(
  parameter int DATA_BITS = 10,
  parameter int DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]          count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic                 do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/adc_y_emu.sv
// Emulated parallel ADC: divided sample clock plus data bus fed from a ramp
// generator or a buffered upstream sample stream.
module adc_y_emu
  import adc_y_emu_pkg::*;
#(
  parameter int DATA_BITS  = 10,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 pattern_en,
  output logic                 adc_clk,
  output logic [DATA_BITS-1:0] y_data_bus,
  output logic                 underflow
);
  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FALL = CW'(HALF - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 adc_clk_q, adc_clk_d;
  logic [DATA_BITS-1:0] y_q, y_d;
  logic [DATA_BITS-1:0] ramp_q, ramp_d;
  logic                 uf_q, uf_d;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0] fifo_rd;
  upd_src_e             src;

  sync_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign s_ready    = !fifo_full;
  assign adc_clk    = adc_clk_q;
  assign y_data_bus = y_q;
  assign underflow  = uf_q;

  // The falling-edge slot is the only point where the bus and ramp move.
  always_comb begin
    src       = pick_src(cnt_q == CNT_FALL, pattern_en, fifo_empty);
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    adc_clk_d = adc_clk_q;
    if (cnt_q == CNT_LAST)      adc_clk_d = 1'b1;
    else if (cnt_q == CNT_FALL) adc_clk_d = 1'b0;
    y_d      = y_q;
    ramp_d   = ramp_q;
    uf_d     = 1'b0;
    fifo_pop = 1'b0;
    case (src)
      SRC_RAMP: begin
        y_d    = ramp_q;
        ramp_d = ramp_q + DATA_BITS'(1);
      end
      SRC_FIFO: begin
        y_d      = fifo_rd;
        fifo_pop = 1'b1;
      end
      SRC_UNDER: uf_d = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      adc_clk_q <= 1'b0;
      y_q       <= '0;
      ramp_q    <= '0;
      uf_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      adc_clk_q <= adc_clk_d;
      y_q       <= y_d;
      ramp_q    <= ramp_d;
      uf_q      <= uf_d;
    end
  end

endmodule
